// File: rtl/s2p.sv
// Serial-to-parallel deserializer: N single-bit beats in, one N-bit word out.
// Define S2P_DBUF_EN to double-buffer (the shift and output registers work independently).
module s2p #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  input  logic         s_data,
  output logic         s_ready,
  output logic         p_valid,
  output logic [N-1:0] p_data,
  input  logic         p_ready
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef S2P_DBUF_EN
  // FULL: a completed word waits in the shift register behind an unaccepted output word.
  typedef enum logic {RX, FULL} state_t;
`else
  typedef enum logic {RX, TX} state_t;
`endif

  state_t        state;
  logic [CW-1:0] count;
  logic [N-1:0]  shift_q;
  logic [N-1:0]  next_shift;
  logic          s_take;
  logic          last_beat;

  assign s_take    = s_valid && s_ready;
  assign last_beat = s_take && (count == LAST);

  always_comb begin
    if (LSB_FIRST) next_shift = {s_data, shift_q[N-1:1]};
    else           next_shift = {shift_q[N-2:0], s_data};
  end

  // NOTE: all state below is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RX;
      count   <= '0;
      shift_q <= '0;
      p_data  <= '0;
      p_valid <= 1'b0;
      s_ready <= 1'b1;
    end else begin
`ifdef S2P_DBUF_EN
      case (state)
        RX: begin
          if (s_take) begin
            shift_q <= next_shift;
            count   <= last_beat ? '0 : count + CW'(1);
          end
          if (last_beat) begin
            if (!p_valid || p_ready) begin
              p_data  <= next_shift;
              p_valid <= 1'b1;
            end else begin
              state   <= FULL;
              s_ready <= 1'b0;
            end
          end else if (p_valid && p_ready) begin
            p_valid <= 1'b0;
          end
        end
        FULL: begin
          // p_valid stays high: the parked word replaces the one being accepted.
          if (p_ready) begin
            p_data  <= shift_q;
            state   <= RX;
            s_ready <= 1'b1;
          end
        end
      endcase
`else
      case (state)
        RX: begin
          if (s_take) begin
            shift_q <= next_shift;
            if (count == LAST) begin
              count   <= '0;
              p_data  <= next_shift;
              state   <= TX;
              s_ready <= 1'b0;
              p_valid <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        TX: begin
          if (p_ready) begin
            state   <= RX;
            s_ready <= 1'b1;
            p_valid <= 1'b0;
          end
        end
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_s2p.sv
// Self-checking bench for s2p: LSB-first and MSB-first instances fed the same serial stream,
// scoreboard of expected words popped on each parallel handshake.
module tb_s2p;

  logic       clk = 1'b0;
  logic       rstn;
  logic       s_valid;
  logic       s_data;
  logic       p_ready;
  logic       s_ready, p_valid;
  logic [7:0] p_data;
  logic       s_ready_m, p_valid_m;
  logic [7:0] p_data_m;

  always #5 clk = ~clk;

  s2p #(.N(8), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready)
  );

  s2p #(.N(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_m),
    .p_valid(p_valid_m), .p_data(p_data_m), .p_ready(p_ready)
  );

  typedef struct {
    logic [7:0] lsb;
    logic [7:0] msb;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   pushed     = 0;
  int   popped     = 0;
  int   stall_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp)
      else begin
        mismatched++;
        $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Inputs change #1 after posedge; a beat is accepted at the next posedge if s_ready is high
  // at the intervening negedge.
  task automatic send_bit(input logic b);
    logic acc;
    int   waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = b;
    forever begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      stall_cnt++;
      waited++;
      if (waited > 50) begin
        compared++;
        mismatched++;
        $error("FAIL s_ready_timeout: observed 0 expected 1 within 50 cycles");
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Plays the p2s side: word serialised LSB first, optional random idle gaps.
  task automatic send_word(input logic [7:0] w, input bit gaps);
    exp_t e;
    e.lsb = w;
    e.msb = bitrev(w);
    sb.push_back(e);
    pushed++;
    for (int i = 0; i < 8; i++) begin
      if (gaps && ($urandom_range(1) == 1)) idle(1);
      send_bit(w[i]);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && p_valid && p_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL unexpected_word: observed %0h expected none", p_data);
      end else begin
        e = sb.pop_front();
        popped++;
        check("p_data_lsb", 32'(p_data), 32'(e.lsb));
        check("p_valid_msb", 32'(p_valid_m), 32'd1);
        check("p_data_msb", 32'(p_data_m), 32'(e.msb));
      end
    end
  end

  initial begin
    logic sready_stall;
    int   drain;
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = 1'b0;
    p_ready = 1'b1;
`ifdef S2P_DBUF_EN
    sready_stall = 1'b1;
`else
    sready_stall = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_p_valid", 32'(p_valid), 32'd0);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_p_data_msb", 32'(p_data_m), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", 32'(s_ready), 32'd1);

    // 1,0,1,0,0,1,0,1 -> 0xA5; valid one cycle after the 8th beat, gone the next.
    send_word(8'hA5, 1'b0);
    check("a5_p_valid", 32'(p_valid), 32'd1);
    check("a5_p_data", 32'(p_data), 32'hA5);
    check("a5_s_ready", 32'(s_ready), 32'(sready_stall));
    @(posedge clk);
    #1;
    check("a5_p_valid_drop", 32'(p_valid), 32'd0);

    // 1,1,0,0,0,0,0,0 -> 0x03 LSB first, 0xC0 MSB first.
    send_word(8'h03, 1'b0);
    check("03_p_data", 32'(p_data), 32'h03);
    check("c0_p_data_msb", 32'(p_data_m), 32'hC0);
    idle(2);

    // Downstream stall for 10 cycles.
    p_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("stall_p_valid", 32'(p_valid), 32'd1);
      check("stall_p_data", 32'(p_data), 32'h3C);
      check("stall_s_ready", 32'(s_ready), 32'(sready_stall));
      @(posedge clk);
      #1;
    end
    p_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_p_valid", 32'(p_valid), 32'd0);
    check("stall_release_s_ready", 32'(s_ready), 32'd1);

    // Random idle gaps inside words.
    send_word(8'h00, 1'b1);
    send_word(8'hFF, 1'b1);
    send_word(8'h81, 1'b1);
    idle(3);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rstn = 1'b0;
    #2;
    check("midrst_p_valid", 32'(p_valid), 32'd0);
    check("midrst_p_data", 32'(p_data), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    check("midrst_p_valid_after", 32'(p_valid), 32'd0);
    send_word(8'h5A, 1'b0);
    check("5a_p_data", 32'(p_data), 32'h5A);
    idle(3);

    // Back-to-back loopback of every byte value.
    stall_cnt = 0;
    for (int w = 0; w < 256; w++) send_word(8'(w), 1'b0);
`ifdef S2P_DBUF_EN
    check("loop_stall_cycles", 32'(stall_cnt), 32'd0);
`else
    check("loop_stall_cycles", 32'(stall_cnt), 32'd255);
`endif

    drain = 0;
    while (sb.size() != 0 && drain < 100) begin
      @(posedge clk);
      drain++;
    end
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("words_received", 32'(popped), 32'(pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/s2p.md
Name: s2p

Overview:
- Serial-to-parallel deserializer. Sits directly downstream of the team's parallel-to-serial stage and consumes its serial stream.
- Accepts single-bit beats under a valid/ready handshake and assembles N-bit words, LSB first.
- Presents each assembled word on a parallel valid/ready interface.
- Together with p2s it forms a loopback path: p2s -> s2p, in which s2p returns the original word unchanged.

Parameters:
- N, 8, word width in bits; N >= 2. The internal beat counter is $clog2(N) bits wide.
- LSB_FIRST, 1, 1: the first serial bit becomes p_data[0]. 0: the first serial bit becomes p_data[N-1].

Ports:
- clk  input  1  Single clock. All state updates on posedge.
- rstn  input  1  Asynchronous, active-low reset.
- s_valid  input  1  Serial beat valid (from the upstream s_valid).
- s_data  input  1  Serial data bit.
- s_ready  output  1  Serial beat accepted when s_valid && s_ready at posedge clk.
- p_valid  output  1  Parallel word valid.
- p_data  output  N  Assembled word.
- p_ready  input  1  Downstream accepts the word when p_valid && p_ready at posedge clk.

Behaviour:
- Reset (asynchronous, rstn=0): state=RX, count=0, shift register=0, output register=0, p_valid=0, p_data=0.
  - s_ready=1 from the first cycle after rstn deasserts.
  - Asserting rstn mid-word or mid-handshake discards all partial and pending data immediately.
- State machine (baseline build), 2 states, Moore outputs:
  - RX: s_ready=1, p_valid=0.
    - Each accepted beat shifts s_data into the shift register and increments count.
    - LSB_FIRST=1: shift right, insert at bit N-1. LSB_FIRST=0: shift left, insert at bit 0.
    - On the accepted beat with count==N-1: load the output register with the completed word, set count=0, go to TX.
    - With s_valid=0: hold, no shift, no count change. Idle gaps between beats are legal anywhere in a word.
  - TX: s_ready=0, p_valid=1, p_data=output register, held stable.
    - On p_ready=1: go to RX.
    - On p_ready=0: hold TX indefinitely, with p_data and p_valid unchanged.
- Latency: p_valid rises the cycle after the Nth beat is accepted. Minimum period per word is N+1 cycles.
- count wraps from N-1 to 0 only on word completion. It never exceeds N-1.
- p_data changes only on entry to TX. p_valid never drops without a handshake.
- p_ready while p_valid=0 is ignored.
- No combinational path from p_ready or s_valid to any output.

Optional Feature:
- Macro: S2P_DBUF_EN
- Without the macro: behaviour is exactly as above, single-buffered. Serial input stalls while a word waits downstream.
- With the macro: double-buffered, so the shift register and the output register work independently.
  - s_ready=1 unless a word has completed in the shift register while the output register still holds an unaccepted word (state FULL).
  - The output register's valid flag sets on word completion and clears on handshake.
  - On completion, when the output register is empty or is being accepted in the same cycle, the new word loads directly and p_valid stays 1 with no bubble.
  - In FULL, the completed word transfers on the next p_ready handshake, then s_ready returns to 1.
  - Sustained throughput is one word per N cycles when p_ready=1.

Test Plan:
- Reset, then 8 consecutive beats 1,0,1,0,0,1,0,1 with p_ready=1 (N=8, LSB_FIRST=1) -> p_data=0xA5 and p_valid=1 exactly one cycle after the 8th beat; p_valid low the next cycle.
- Same bits with LSB_FIRST=0 -> p_data=0xA5 bit-reversed = 0xA5 with first bit in bit 7; use bits 1,1,0,0,0,0,0,0 -> p_data=0xC0 (LSB_FIRST=0), 0x03 (LSB_FIRST=1).
- Word 0x3C, then p_ready held 0 for 10 cycles -> p_valid=1 and p_data=0x3C stable throughout; s_ready=0 (baseline); word consumed on the cycle p_ready=1.
- Random s_valid gaps (50% duty) while streaming words 0x00, 0xFF, 0x81 -> the three words arrive in order and intact; count never exceeds 7.
- rstn pulsed low after 4 beats of a word -> p_valid=0 and s_ready=1 after release; the next 8 beats form a clean word, e.g. 0x5A.
- p2s -> s2p loopback, 256 words 0x00..0xFF, p_ready=1; with S2P_DBUF_EN also run back-to-back serial input -> every word matches, and with the macro defined no bubble in s_ready occurs.
